// File: rtl/qr_pkg.sv
// Shared types and constants for the QR Gram-Schmidt sequencer: op codes,
// controller state encoding and index width.
package qr_pkg;

    localparam int QR_IDX_W = 4;

    typedef logic [1:0] op_code_t;

    localparam op_code_t OP_NORM = 2'd0;
    localparam op_code_t OP_PROJ = 2'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/qr_idx_gen.sv
// Modified Gram-Schmidt index walker: NORM(k,k) then PROJ(k,j) for j=k+1..N-1,
// for k=0..N-1. Flags the final NORM(N-1,N-1) so the controller can finish.
module qr_idx_gen
    import qr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                advance,
    output op_code_t            op,
    output logic [QR_IDX_W-1:0] k,
    output logic [QR_IDX_W-1:0] j,
    output logic                last
);

    localparam logic [QR_IDX_W-1:0] LAST_IDX = QR_IDX_W'(N - 1);

    op_code_t            op_reg, op_next;
    logic [QR_IDX_W-1:0] k_reg, k_next;
    logic [QR_IDX_W-1:0] j_reg, j_next;

    always_comb begin
        op_next = op_reg;
        k_next  = k_reg;
        j_next  = j_reg;
        if (clear) begin
            op_next = OP_NORM;
            k_next  = '0;
            j_next  = '0;
        end else if (advance) begin
            if (op_reg == OP_NORM) begin
                // The final NORM has no successor; the controller leaves for FIN.
                if (k_reg != LAST_IDX) begin
                    op_next = OP_PROJ;
                    j_next  = k_reg + 1'b1;
                end
            end else if (j_reg != LAST_IDX) begin
                j_next = j_reg + 1'b1;
            end else begin
                // Next pivot's NORM carries j equal to the new k.
                op_next = OP_NORM;
                k_next  = k_reg + 1'b1;
                j_next  = k_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg <= OP_NORM;
            k_reg  <= '0;
            j_reg  <= '0;
        end else begin
            op_reg <= op_next;
            k_reg  <= k_next;
            j_reg  <= j_next;
        end
    end

    assign op   = op_reg;
    assign k    = k_reg;
    assign j    = j_reg;
    assign last = (op_reg == OP_NORM) && (k_reg == LAST_IDX);

endmodule

// File: rtl/qr_seq_ctrl.sv
// QR decomposition sequencer: issues NORM/PROJ ops to a datapath with a
// valid/ready handshake. Define QR_SEQ_TIMEOUT_EN to add the WAIT watchdog.
module qr_seq_ctrl
    import qr_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    output logic                op_valid,
    input  logic                op_ready,
    output logic [1:0]          op_code,
    output logic [QR_IDX_W-1:0] op_k,
    output logic [QR_IDX_W-1:0] op_j,
    input  logic                dp_done,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t              state_reg, state_next;
    logic                idx_clear;
    logic                idx_adv;
    logic                idx_last;
    op_code_t            idx_op;
    logic [QR_IDX_W-1:0] idx_k;
    logic [QR_IDX_W-1:0] idx_j;
    logic                wdog_hit;

    qr_idx_gen #(.N(N)) u_idx (
        .clk     (clk),
        .reset   (reset),
        .clear   (idx_clear),
        .advance (idx_adv),
        .op      (idx_op),
        .k       (idx_k),
        .j       (idx_j),
        .last    (idx_last)
    );

`ifdef QR_SEQ_TIMEOUT_EN
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    logic [7:0] wdog_reg, wdog_next;
    logic       err_reg, err_next;

    assign wdog_hit = (wdog_reg + 8'd1) == TMO;

    // Counter sits at zero outside WAIT, so it is clear on every WAIT entry.
    always_comb begin
        wdog_next = '0;
        err_next  = err_reg;
        if (state_reg == WAIT) begin
            wdog_next = wdog_reg + 8'd1;
        end
        if (state_reg == IDLE && start) begin
            err_next = 1'b0;
        end
        if (state_reg == WAIT && !abort && !dp_done && wdog_hit) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            wdog_reg <= wdog_next;
            err_reg  <= err_next;
        end
    end

    assign err = err_reg;
`else
    assign wdog_hit = 1'b0;
    assign err      = 1'b0;
`endif

    // Abort outranks the handshake and completion inputs in every busy state.
    always_comb begin
        state_next = state_reg;
        idx_clear  = 1'b0;
        idx_adv    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = ISSUE;
                    idx_clear  = 1'b1;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (op_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (dp_done) begin
                    idx_adv    = 1'b1;
                    state_next = idx_last ? FIN : ISSUE;
                end else if (wdog_hit) begin
                    state_next = IDLE;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign op_valid = (state_reg == ISSUE);
    assign op_code  = idx_op;
    assign op_k     = idx_k;
    assign op_j     = idx_j;
    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == FIN);

endmodule

// File: tb/tb_qr_seq_ctrl.sv
// Scoreboard bench for qr_seq_ctrl: N=4 and N=2 instances, handshake stalls,
// abort, mid-run reset, ignored pulses and the optional watchdog.
module tb_qr_seq_ctrl;
    import qr_pkg::*;

    typedef struct packed {
        logic [1:0] code;
        logic [3:0] k;
        logic [3:0] j;
    } op_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, abort, op_ready, dp_done, sel;

    logic       v4, busy4, done4, err4;
    logic [1:0] code4;
    logic [3:0] k4, j4;
    logic       v2, busy2, done2, err2;
    logic [1:0] code2;
    logic [3:0] k2, j2;

    qr_seq_ctrl #(.N(4), .TIMEOUT(8)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .start    (start & ~sel),
        .abort    (abort & ~sel),
        .op_valid (v4),
        .op_ready (op_ready),
        .op_code  (code4),
        .op_k     (k4),
        .op_j     (j4),
        .dp_done  (dp_done & ~sel),
        .busy     (busy4),
        .done     (done4),
        .err      (err4)
    );

    qr_seq_ctrl #(.N(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .start    (start & sel),
        .abort    (abort & sel),
        .op_valid (v2),
        .op_ready (op_ready),
        .op_code  (code2),
        .op_k     (k2),
        .op_j     (j2),
        .dp_done  (dp_done & sel),
        .busy     (busy2),
        .done     (done2),
        .err      (err2)
    );

    logic       op_valid, busy, done, err;
    logic [1:0] op_code;
    logic [3:0] op_k, op_j;

    assign op_valid = sel ? v2    : v4;
    assign op_code  = sel ? code2 : code4;
    assign op_k     = sel ? k2    : k4;
    assign op_j     = sel ? j2    : j4;
    assign busy     = sel ? busy2 : busy4;
    assign done     = sel ? done2 : done4;
    assign err      = sel ? err2  : err4;

    int  n_checks = 0;
    int  n_pass   = 0;
    op_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input int n);
        for (int kk = 0; kk < n; kk++) begin
            exp_q.push_back('{code: OP_NORM, k: 4'(kk), j: 4'(kk)});
            for (int jj = kk + 1; jj < n; jj++)
                exp_q.push_back('{code: OP_PROJ, k: 4'(kk), j: 4'(jj)});
        end
    endtask

    // One decomposition: datapath answers 3 cycles after each accept.
    task automatic run(input int n, input int stall, input int abort_after,
                       input bit reset_at_23, input bit noise);
        int  pending    = 0;
        int  stall_left = stall;
        int  accepted   = 0;
        bit  holding    = 0;
        bit  waiting;
        bit  fin        = 0;
        op_t e;
        exp_q.delete();
        push_seq(n);
        start    = 1'b1;
        op_ready = (stall == 0);
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            dp_done = 1'b0;
            start   = 1'b0;
            abort   = 1'b0;
            if (done) begin
                check("fin_queue_empty", exp_q.size(), 0);
                if (noise) start = 1'b1;
                step();
                start = 1'b0;
                check("idle_after_done", busy, 0);
                check("done_single", done, 0);
                fin = 1;
            end else begin
                waiting = (pending > 0);
                if (waiting) begin
                    check("valid_in_wait", op_valid, 0);
                    pending--;
                    if (pending == 0) dp_done = 1'b1;
                end
                if (waiting && dp_done && abort_after == accepted) begin
                    abort = 1'b1;
                    step();
                    abort   = 1'b0;
                    dp_done = 1'b0;
                    check("abort_idle", busy, 0);
                    check("abort_no_done", done, 0);
                    check("abort_no_valid", op_valid, 0);
                    return;
                end else if (!waiting && op_valid) begin
                    if (exp_q.size() == 0) begin
                        check("extra_op", 1, 0);
                        return;
                    end
                    e = exp_q[0];
                    check("op_code", op_code, e.code);
                    check("op_k", op_k, e.k);
                    check("op_j", op_j, e.j);
                    if (reset_at_23 && e.k == 4'd2 && e.j == 4'd3) begin
                        reset    = 1'b1;
                        op_ready = 1'b0;
                        step();
                        check("reset_outs_zero",
                              {op_valid, op_code, op_k, op_j, busy, done, err}, 0);
                        reset = 1'b0;
                        return;
                    end
                    if (stall_left > 0) begin
                        stall_left--;
                        holding  = 1;
                        op_ready = 1'b0;
                    end else begin
                        op_ready = 1'b1;
                        holding  = 0;
                        void'(exp_q.pop_front());
                        accepted++;
                        pending = 3;
                        $display("op %0d accepted: code=%0d k=%0d j=%0d", accepted, e.code, e.k, e.j);
                    end
                    if (noise) begin
                        start   = 1'b1;
                        dp_done = 1'b1;
                    end
                end else if (!waiting && holding) begin
                    check("stall_valid_held", op_valid, 1);
                end
                step();
            end
        end
        if (!fin) check("run_cycle_budget", 0, 1);
    endtask

    task automatic timeout_test();
        op_ready = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        check("tmo_issue_valid", op_valid, 1);
        step();
        for (int i = 1; i <= 8; i++) begin
            step();
`ifdef QR_SEQ_TIMEOUT_EN
            if (i < 8) begin
                check("tmo_still_busy", busy, 1);
                check("tmo_err_low", err, 0);
            end else begin
                check("tmo_busy_dropped", busy, 0);
                check("tmo_err_set", err, 1);
            end
`else
            check("nowdog_busy", busy, 1);
            check("nowdog_err", err, 0);
`endif
        end
`ifdef QR_SEQ_TIMEOUT_EN
        start = 1'b1;
        step();
        start = 1'b0;
        check("tmo_err_cleared", err, 0);
        check("tmo_restart_busy", busy, 1);
`endif
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("tmo_abort_idle", busy, 0);
    endtask

    initial begin
        sel      = 1'b0;
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        op_ready = 1'b0;
        dp_done  = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("reset_state", {op_valid, op_code, op_k, op_j, busy, done, err}, 0);

        run(4, 0, -1, 0, 0);
        run(4, 5, -1, 0, 0);
        run(4, 0, 4, 0, 0);
        run(4, 0, -1, 0, 0);
        run(4, 0, -1, 1, 0);
        run(4, 0, -1, 0, 1);
        timeout_test();

        sel = 1'b1;
        step();
        run(2, 0, -1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
